// File: rtl/gs_pkg.sv
// gs_pkg: shared state, status codes and constants for the Goldschmidt iteration controller.
package gs_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SEED, S_WAIT, S_EVAL, S_DONE} state_t;
    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_MAXIT = 2'b01;
    localparam logic [1:0] ST_DIVZ  = 2'b10;
    localparam logic [1:0] ST_RANGE = 2'b11;
    localparam logic [7:0] FP_ONE     = 8'h38;
    localparam logic [3:0] EXP_BIAS   = 4'd7;
    localparam logic [3:0] SEED_BASE  = 4'(2 * EXP_BIAS);
    localparam logic [7:0] NEAR_ONE_A = 8'h37;
    localparam logic [7:0] NEAR_ONE_B = 8'h36;
    localparam logic [7:0] NEAR_ONE_C = 8'h34;
    // C close enough to 1.0, or a vanished correction term, ends the iteration
    function automatic logic is_converged(input logic [7:0] c, input logic [7:0] xinew);
        return c == FP_ONE || c == NEAR_ONE_A || c == NEAR_ONE_B || c == NEAR_ONE_C || xinew == 8'h00;
    endfunction
endpackage

// File: rtl/gs_iter_ctrl_if.sv
// gs_iter_ctrl_if: operand request, result and iteration datapath bundle of the controller.
interface gs_iter_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] dp_a;
    logic [7:0] dp_b;
    logic [7:0] dp_xi;
    logic [7:0] dp_c;
    logic [7:0] dp_d;
    logic [7:0] dp_xinew;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_q;
    logic [1:0] res_status;
    logic [2:0] res_iter;
    modport master (
        output in_valid, in_a, in_b, res_ready, dp_c, dp_d, dp_xinew,
        input  in_ready, res_valid, res_q, res_status, res_iter, dp_a, dp_b, dp_xi
    );
    modport slave (
        input  in_valid, in_a, in_b, res_ready, dp_c, dp_d, dp_xinew,
        output in_ready, res_valid, res_q, res_status, res_iter, dp_a, dp_b, dp_xi
    );
endinterface

// File: rtl/gs_seed_gen.sv
// gs_seed_gen: reciprocal seed for divisor exponent; exponent 15 has no representable seed.
module gs_seed_gen import gs_pkg::*; (
    input  logic [3:0] b_exp,
    output logic [7:0] xi,
    output logic       range_err
);
    always_comb begin
        xi = {1'b0, SEED_BASE - b_exp, 3'b000};
        range_err = b_exp == 4'hF;
    end
endmodule

// File: rtl/gs_iter_ctrl.sv
// gs_iter_ctrl: sequential Goldschmidt division controller reusing one external iteration datapath.
module gs_iter_ctrl import gs_pkg::*; #(
    parameter int DP_LAT   = 2,
    parameter int MAX_ITER = 3
) (
    input logic           clk,
    input logic           rst,
    gs_iter_ctrl_if.slave bus
);
    localparam logic [3:0] WAIT_LD = 4'(DP_LAT - 1);
    localparam logic [2:0] MAX_IT  = 3'(MAX_ITER);
    state_t     state;
    logic [7:0] a_r, b_r, c_r, d_r, xn_r, seed;
    logic [3:0] wait_cnt;
    logic [2:0] iter, iter_n;
    logic       range_err, conv;
    gs_seed_gen u_seed (.b_exp(b_r[6:3]), .xi(seed), .range_err(range_err));
    assign iter_n = iter + 3'd1;
    assign conv = is_converged(c_r, xn_r);
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            bus.in_ready   <= 1'b1;
            bus.res_valid  <= 1'b0;
            bus.res_q      <= 8'h00;
            bus.res_status <= ST_OK;
            bus.res_iter   <= 3'd0;
            bus.dp_a       <= 8'h00;
            bus.dp_b       <= 8'h00;
            bus.dp_xi      <= 8'h00;
            a_r            <= 8'h00;
            b_r            <= 8'h00;
            c_r            <= 8'h00;
            d_r            <= 8'h00;
            xn_r           <= 8'h00;
            wait_cnt       <= 4'd0;
            iter           <= 3'd0;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    a_r          <= bus.in_a;
                    b_r          <= bus.in_b;
                    iter         <= 3'd0;
                    bus.in_ready <= 1'b0;
                    state        <= S_SEED;
                end
                S_SEED: if (b_r == 8'h00 || a_r == 8'h00 || range_err) begin
                    bus.res_q      <= 8'h00;
                    bus.res_iter   <= 3'd0;
                    bus.res_status <= b_r == 8'h00 ? ST_DIVZ : a_r == 8'h00 ? ST_OK : ST_RANGE;
                    bus.res_valid  <= 1'b1;
                    state          <= S_DONE;
                end else begin
                    bus.dp_a  <= a_r;
                    bus.dp_b  <= b_r;
                    bus.dp_xi <= seed;
                    wait_cnt  <= WAIT_LD;
                    state     <= S_WAIT;
                end
                S_WAIT: if (wait_cnt != 4'd0) begin
                    wait_cnt <= wait_cnt - 4'd1;
                end else begin
                    c_r   <= bus.dp_c;
                    d_r   <= bus.dp_d;
                    xn_r  <= bus.dp_xinew;
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    iter <= iter_n;
                    if (conv || iter_n == MAX_IT) begin
                        bus.res_q      <= d_r;
                        bus.res_status <= conv ? ST_OK : ST_MAXIT;
                        bus.res_iter   <= iter_n;
                        bus.res_valid  <= 1'b1;
                        state          <= S_DONE;
                    end else begin
                        bus.dp_xi <= xn_r;
                        wait_cnt  <= WAIT_LD;
                        state     <= S_WAIT;
                    end
                end
                S_DONE: if (bus.res_ready) begin
                    bus.res_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gs_iter_ctrl.sv
// tb_gs_iter_ctrl: random and directed checks of gs_iter_ctrl against a per-operation division model.
module tb_gs_iter_ctrl;
    localparam int DP_LAT   = 2;
    localparam int MAX_ITER = 3;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0, n_fail = 0;
    int   mode = 0;
    logic [7:0] salt = 8'h00;
    gs_iter_ctrl_if bus();
    gs_iter_ctrl #(.DP_LAT(DP_LAT), .MAX_ITER(MAX_ITER)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // datapath stand-in: mode 0 converges at once, mode 1 never converges, mode 2 pseudo-random
    function automatic logic [23:0] dpf(input int md, input logic [7:0] s, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] xi);
        logic [7:0] h, c, d, xn;
        h = (a * 8'd31) ^ (b * 8'd17) ^ (xi * 8'd7) ^ s;
        if (md == 0) begin
            c = 8'h38; d = a; xn = xi;
        end else if (md == 1) begin
            c = 8'h30; d = a ^ xi; xn = xi + 8'h09;
        end else begin
            c = h[1:0] != 2'd0 ? h ^ 8'h5A : h[3:2] == 2'd0 ? 8'h38 : h[3:2] == 2'd1 ? 8'h37 : h[3:2] == 2'd2 ? 8'h36 : 8'h34;
            d = h ^ 8'hC3;
            xn = h[7:5] == 3'd0 ? 8'h00 : h + 8'h13;
        end
        return {c, d, xn};
    endfunction
    always_comb {bus.dp_c, bus.dp_d, bus.dp_xinew} = dpf(mode, salt, bus.dp_a, bus.dp_b, bus.dp_xi);
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // reference: whole-operation result, pass-by-pass multipliers and result latency
    logic       busy = 1'b0, rdy_prev = 1'b1, rv_prev = 1'b0, exp_rv, m_spec;
    int         t, m_L, m_it, pidx;
    logic [7:0] m_a, m_b, m_q, x, hd_a, hd_b, hd_xi;
    logic [1:0] m_st;
    logic [7:0] xl [1:7];
    logic [23:0] r;
    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0; rdy_prev = 1'b1; rv_prev = 1'b0;
            hd_a = 8'h00; hd_b = 8'h00; hd_xi = 8'h00;
            chk("rst_in_ready", bus.in_ready, 1);
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_res_q", bus.res_q, 0);
            chk("rst_res_status", bus.res_status, 0);
            chk("rst_res_iter", bus.res_iter, 0);
            chk("rst_dp_a", bus.dp_a, 0);
            chk("rst_dp_b", bus.dp_b, 0);
            chk("rst_dp_xi", bus.dp_xi, 0);
        end else begin
            if (busy && rv_prev && bus.res_ready) busy = 1'b0;
            else if (busy) t++;
            else if (bus.in_valid && rdy_prev) begin
                busy = 1'b1; t = 1;
                m_a = bus.in_a; m_b = bus.in_b; m_q = 8'h00; m_it = 0; m_spec = 1'b1;
                if (m_b == 8'h00) m_st = 2'b10;
                else if (m_a == 8'h00) m_st = 2'b00;
                else if (m_b[6:3] == 4'hF) m_st = 2'b11;
                else begin
                    m_spec = 1'b0;
                    x = {1'b0, 4'd14 - m_b[6:3], 3'b000};
                    for (int p = 1; p <= MAX_ITER; p++) begin
                        xl[p] = x;
                        r = dpf(mode, salt, m_a, m_b, x);
                        m_it = p; m_q = r[15:8];
                        if (r[23:16] inside {8'h38, 8'h37, 8'h36, 8'h34} || r[7:0] == 8'h00) begin
                            m_st = 2'b00;
                            break;
                        end
                        m_st = 2'b01;
                        x = r[7:0];
                    end
                end
                m_L = m_spec ? 2 : 2 + m_it * (DP_LAT + 1);
            end
            if (busy && !m_spec && t >= 2) begin
                pidx = (t - 2) / (DP_LAT + 1) + 1;
                if (pidx > m_it) pidx = m_it;
                hd_a = m_a; hd_b = m_b; hd_xi = xl[pidx];
            end
            exp_rv = busy && t >= m_L;
            chk("in_ready", bus.in_ready, !busy);
            chk("res_valid", bus.res_valid, exp_rv);
            chk("dp_a", bus.dp_a, hd_a);
            chk("dp_b", bus.dp_b, hd_b);
            chk("dp_xi", bus.dp_xi, hd_xi);
            if (exp_rv) begin
                chk("res_q", bus.res_q, m_q);
                chk("res_status", bus.res_status, m_st);
                chk("res_iter", bus.res_iter, m_it);
            end
            rdy_prev = !busy; rv_prev = exp_rv;
        end
    end
    task automatic wait_res(inout int lat, input bit noise);
        while (!bus.res_valid && lat < 200) begin
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_a = 8'($urandom);
                bus.in_b = 8'($urandom);
            end
            @(negedge clk); lat++; #1;
        end
        chk("res_timeout", bus.res_valid, 1);
    endtask
    task automatic start(input logic [7:0] a, input logic [7:0] b, input bit noise, output int lat);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        @(negedge clk); lat = 1; #1;
        bus.in_valid = 1'b0;
        wait_res(lat, noise);
    endtask
    task automatic release_res();
        bus.res_ready = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk); #1;
        bus.res_ready = 1'b0;
    endtask
    int lat;
    logic [7:0] ra, rb;
    initial begin
        rst = 1'b1; bus.in_valid = 1'b0; bus.in_a = 8'h00; bus.in_b = 8'h00; bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        start(8'h55, 8'h00, 1'b0, lat);
        chk("divz_lat", lat, 2); chk("divz_status", bus.res_status, 2'b10);
        chk("divz_q", bus.res_q, 0); chk("divz_iter", bus.res_iter, 0); chk("divz_dp_xi", bus.dp_xi, 0);
        release_res();
        mode = 0;
        start(8'h40, 8'h38, 1'b0, lat);
        chk("one_lat", lat, 5); chk("one_q", bus.res_q, 8'h40); chk("one_status", bus.res_status, 0);
        chk("one_iter", bus.res_iter, 1); chk("one_dp_xi", bus.dp_xi, 8'h38);
        release_res();
        mode = 1;
        start(8'h48, 8'h48, 1'b0, lat);
        chk("maxit_lat", lat, 11); chk("maxit_status", bus.res_status, 2'b01);
        chk("maxit_iter", bus.res_iter, 3); chk("maxit_dp_xi", bus.dp_xi, 8'h3A); chk("maxit_q", bus.res_q, 8'h72);
        release_res();
        start(8'h12, 8'h78, 1'b0, lat);
        chk("range_lat", lat, 2); chk("range_status", bus.res_status, 2'b11);
        release_res();
        mode = 0;
        start(8'h10, 8'h50, 1'b0, lat);
        chk("seed10_dp_xi", bus.dp_xi, 8'h20); chk("seed10_q", bus.res_q, 8'h10);
        bus.in_valid = 1'b1; bus.in_a = 8'h40; bus.in_b = 8'h38;
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", bus.res_valid, 1); chk("hold_ready", bus.in_ready, 0); chk("hold_q", bus.res_q, 8'h10);
            #1;
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 1); chk("rel_res_valid", bus.res_valid, 0);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        chk("acc_in_ready", bus.in_ready, 0);
        lat = 1; #1 bus.in_valid = 1'b0;
        wait_res(lat, 1'b0);
        chk("acc_lat", lat, 5); chk("acc_q", bus.res_q, 8'h40);
        release_res();
        mode = 1;
        bus.in_valid = 1'b1; bus.in_a = 8'h48; bus.in_b = 8'h48;
        @(negedge clk); lat = 1; #1 bus.in_valid = 1'b0;
        while (lat < 5) begin @(negedge clk); lat++; #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", bus.in_ready, 1); chk("mid_rst_dp_xi", bus.dp_xi, 0); chk("mid_rst_valid", bus.res_valid, 0);
        #1 rst = 1'b0;
        mode = 0;
        start(8'h40, 8'h38, 1'b0, lat);
        chk("post_rst_lat", lat, 5); chk("post_rst_q", bus.res_q, 8'h40);
        release_res();
        for (int i = 0; i < 80; i++) begin
            mode = $urandom_range(0, 3) > 2 ? 2 : int'($urandom_range(0, 2));
            salt = 8'($urandom);
            ra = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 8'h00;
                1: rb = {1'($urandom), 4'hF, 3'($urandom)};
                default: rb = 8'($urandom);
            endcase
            start(ra, rb, 1'($urandom_range(0, 1)), lat);
            repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
            release_res();
            repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
